// File: rtl/reg_file_mp.sv
// -----------------------------------------------------------------------------
// reg_file_mp : parametrised multi-port register file
//
// Purpose
//   Register file with NUM_RD combinational read ports and two write ports.
//   Write port 1 has priority over port 0 on a same-address collision.
//   Entry 0 can be hardwired to zero (ZERO_REG). After every reset a
//   sequential walker loads each entry with its index (INIT_IDX=1) or with
//   zero (INIT_IDX=0), one entry per cycle. Writes are accepted only once
//   the walker has finished.
//
// Ports
//   clock     in   1            rising-edge clock
//   reset     in   1            synchronous active-high reset
//   rd_addr   in   NUM_RD*AW    read addresses, port k at [k*AW +: AW]
//   rd_data   out  NUM_RD*XLEN  read data, port k at [k*XLEN +: XLEN]
//   wr_en     in   2            write enables, bit p = write port p
//   wr_addr0  in   AW           port-0 write address
//   wr_data0  in   XLEN         port-0 write data
//   wr_addr1  in   AW           port-1 write address
//   wr_data1  in   XLEN         port-1 write data
//   ready     out  1            1 once init is complete
//   wr_clash  out  1            pulse: previous cycle both ports wrote one address
//
// Configuration macro
//   REG_FILE_BYPASS_EN : when defined, a read of an address being written in
//   the same cycle returns the write data (port 1 over port 0).
// -----------------------------------------------------------------------------
module reg_file_mp #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int INIT_IDX = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    input  logic [1:0]             wr_en,
    input  logic [AW-1:0]          wr_addr0,
    input  logic [XLEN-1:0]        wr_data0,
    input  logic [AW-1:0]          wr_addr1,
    input  logic [XLEN-1:0]        wr_data1,
    output logic                   ready,
    output logic                   wr_clash
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

    state_e              state_q, state_d;
    logic [AW-1:0]       ptr_q, ptr_d;
    logic                clash_q, clash_d;
    logic [XLEN-1:0]     mem_q [NUM_REGS];

    logic                init_we_s;
    logic [XLEN-1:0]     init_val_s;
    logic                wr0_ok_s;
    logic                wr1_ok_s;
    logic [NUM_RD*XLEN-1:0] rd_data_s;

    // An address holds real storage: inside the depth and not the hardwired zero entry.
    function automatic logic addr_live(input logic [AW-1:0] a);
        logic in_range;
        logic is_zero;
        in_range = ({1'b0, a} < (AW+1)'(NUM_REGS));
        is_zero  = (ZERO_REG != 0) && (a == {AW{1'b0}});
        return in_range && !is_zero;
    endfunction

    assign ready      = (state_q == ST_RUN);
    assign wr_clash   = clash_q;
    assign wr0_ok_s   = ready && wr_en[0] && addr_live(wr_addr0);
    assign wr1_ok_s   = ready && wr_en[1] && addr_live(wr_addr1);
    assign init_val_s = (INIT_IDX != 0) ? XLEN'(ptr_q) : {XLEN{1'b0}};

    // Control state: FSM state, walker pointer and clash flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_INIT;
            ptr_q   <= {AW{1'b0}};
            clash_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            clash_q <= clash_d;
        end
    end

    // Next-state logic: walker advances one entry per cycle, then RUN.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        clash_d   = 1'b0;
        init_we_s = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_we_s = 1'b1;
                if (ptr_q == LAST_IDX) begin
                    state_d = ST_RUN;
                    ptr_d   = {AW{1'b0}};
                end else begin
                    ptr_d   = ptr_q + AW'(1);
                end
            end
            ST_RUN: begin
                // Dropped writes (zero entry, out of range) never raise the flag.
                clash_d = wr0_ok_s && wr1_ok_s && (wr_addr0 == wr_addr1);
            end
            default: begin
                state_d = ST_INIT;
                ptr_d   = {AW{1'b0}};
            end
        endcase
    end

    // Storage array: walker writes in INIT, ports write in RUN (port 1 last, so it wins).
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (init_we_s) begin
                mem_q[ptr_q] <= init_val_s;
            end else begin
                if (wr0_ok_s) begin
                    mem_q[wr_addr0] <= wr_data0;
                end
                if (wr1_ok_s) begin
                    mem_q[wr_addr1] <= wr_data1;
                end
            end
        end
    end

    // Read ports: zero while not ready or for non-live addresses, else stored/bypassed data.
    always_comb begin : read_mux
        logic [AW-1:0]   a;
        logic [XLEN-1:0] v;
        rd_data_s = {(NUM_RD*XLEN){1'b0}};
        a         = {AW{1'b0}};
        v         = {XLEN{1'b0}};
        for (int k = 0; k < NUM_RD; k++) begin
            a = rd_addr[k*AW +: AW];
            if (ready && addr_live(a)) begin
                v = mem_q[a];
`ifdef REG_FILE_BYPASS_EN
                if (wr0_ok_s && (wr_addr0 == a)) begin
                    v = wr_data0;
                end else begin
                    v = v;
                end
                if (wr1_ok_s && (wr_addr1 == a)) begin
                    v = wr_data1;
                end else begin
                    v = v;
                end
`endif
            end else begin
                v = {XLEN{1'b0}};
            end
            rd_data_s[k*XLEN +: XLEN] = v;
        end
    end

    assign rd_data = rd_data_s;

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp (default parameters). Inputs are driven
// on the falling edge, outputs compared 1 ns later, and a behavioural model
// (plain array + init countdown) is advanced just before each rising edge.
module tb_reg_file_mp;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;
    localparam int NUM_RD   = 2;
    localparam int AW       = 5;

    logic                   clock = 1'b0;
    logic                   reset;
    logic [NUM_RD*AW-1:0]   rd_addr;
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic [1:0]             wr_en;
    logic [AW-1:0]          wr_addr0, wr_addr1;
    logic [XLEN-1:0]        wr_data0, wr_data1;
    logic                   ready;
    logic                   wr_clash;

    int checks = 0;
    int errors = 0;

    // reference model
    logic [XLEN-1:0] mem_m [NUM_REGS];
    int              init_cnt;
    bit              ready_m;
    bit              clash_m;

    reg_file_mp #(
        .XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD),
        .ZERO_REG(1), .INIT_IDX(1)
    ) dut (
        .clock(clock), .reset(reset),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en),
        .wr_addr0(wr_addr0), .wr_data0(wr_data0),
        .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .ready(ready), .wr_clash(wr_clash)
    );

    always #5 clock = ~clock;

    // Expected value of a read of address a with the currently driven inputs.
    function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
        logic [XLEN-1:0] v;
        if (!ready_m || a == 5'd0) return 32'd0;
        v = mem_m[a];
`ifdef REG_FILE_BYPASS_EN
        if (wr_en[0] && wr_addr0 == a) v = wr_data0;
        if (wr_en[1] && wr_addr1 == a) v = wr_data1;
`endif
        return v;
    endfunction

    // Advance the model by one rising edge with the current inputs, then move to the falling edge.
    task automatic step();
        if (reset) begin
            init_cnt = 0;
            ready_m  = 1'b0;
            clash_m  = 1'b0;
            for (int i = 0; i < NUM_REGS; i++) mem_m[i] = XLEN'(i);
        end else if (!ready_m) begin
            init_cnt = init_cnt + 1;
            if (init_cnt == NUM_REGS) ready_m = 1'b1;
            clash_m = 1'b0;
        end else begin
            clash_m = (wr_en == 2'b11) && (wr_addr0 == wr_addr1) && (wr_addr0 != 5'd0);
            if (wr_en[0] && wr_addr0 != 5'd0) mem_m[wr_addr0] = wr_data0;
            if (wr_en[1] && wr_addr1 != 5'd0) mem_m[wr_addr1] = wr_data1;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive_idle();
        wr_en    = 2'b00;
        wr_addr0 = 5'd0;
        wr_addr1 = 5'd0;
        wr_data0 = 32'd0;
        wr_data1 = 32'd0;
    endtask

    task automatic test_reset();
        logic [AW-1:0] a0, a1;
        reset = 1'b1;
        drive_idle();
        rd_addr = {NUM_RD*AW{1'b0}};
        step();
        reset = 1'b0;
        for (int c = 0; c < NUM_REGS; c++) begin
            a0 = AW'($urandom_range(0, NUM_REGS-1));
            a1 = AW'($urandom_range(0, NUM_REGS-1));
            rd_addr  = {a1, a0};
            wr_en    = 2'($urandom_range(0, 3));
            wr_addr0 = AW'($urandom);
            wr_addr1 = AW'($urandom);
            wr_data0 = $urandom;
            wr_data1 = $urandom;
            if (c == 10) begin
                wr_en    = 2'b01;
                wr_addr0 = 5'd20;
                wr_data0 = 32'h0000_1234;
            end
            #1;
            checks++;
            if (ready !== 1'b0) begin
                errors++;
                $display("FAIL init_ready cycle %0d: got %b expected 0", c, ready);
            end
            checks++;
            if (rd_data !== {NUM_RD*XLEN{1'b0}}) begin
                errors++;
                $display("FAIL init_rd_zero cycle %0d: got %h expected 0", c, rd_data);
            end
            checks++;
            if (wr_clash !== 1'b0) begin
                errors++;
                $display("FAIL init_clash cycle %0d: got %b expected 0", c, wr_clash);
            end
            step();
        end
        drive_idle();
        rd_addr = {5'd20, 5'd5};
        #1;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_init: got %b expected 1", ready);
        end
        checks++;
        if (rd_data[31:0] !== 32'd5) begin
            errors++;
            $display("FAIL init_value_5: got %h expected 00000005", rd_data[31:0]);
        end
        checks++;
        if (rd_data[63:32] !== 32'd20) begin
            errors++;
            $display("FAIL init_write_ignored_20: got %h expected 00000014", rd_data[63:32]);
        end
        step();
    endtask

    task automatic test_write_read();
        logic [XLEN-1:0] same_exp;
`ifdef REG_FILE_BYPASS_EN
        same_exp = 32'hDEAD_BEEF;
`else
        same_exp = 32'd3;
`endif
        drive_idle();
        wr_en    = 2'b01;
        wr_addr0 = 5'd3;
        wr_data0 = 32'hDEAD_BEEF;
        rd_addr  = {5'd4, 5'd3};
        #1;
        checks++;
        if (rd_data[31:0] !== same_exp) begin
            errors++;
            $display("FAIL write_same_cycle: got %h expected %h", rd_data[31:0], same_exp);
        end
        step();
        drive_idle();
        #1;
        checks++;
        if (rd_data[31:0] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_next_cycle: got %h expected deadbeef", rd_data[31:0]);
        end
        checks++;
        if (rd_data[63:32] !== 32'd4) begin
            errors++;
            $display("FAIL neighbour_untouched: got %h expected 00000004", rd_data[63:32]);
        end
        step();
    endtask

    task automatic test_clash();
        drive_idle();
        wr_en    = 2'b11;
        wr_addr0 = 5'd7;
        wr_addr1 = 5'd7;
        wr_data0 = 32'h0000_AAAA;
        wr_data1 = 32'h0000_BBBB;
        rd_addr  = {5'd7, 5'd7};
        #1;
        checks++;
        if (wr_clash !== 1'b0) begin
            errors++;
            $display("FAIL clash_before: got %b expected 0", wr_clash);
        end
        step();
        drive_idle();
        #1;
        checks++;
        if (wr_clash !== 1'b1) begin
            errors++;
            $display("FAIL clash_pulse: got %b expected 1", wr_clash);
        end
        checks++;
        if (rd_data[31:0] !== 32'h0000_BBBB) begin
            errors++;
            $display("FAIL clash_port1_wins: got %h expected 0000bbbb", rd_data[31:0]);
        end
        step();
        #1;
        checks++;
        if (wr_clash !== 1'b0) begin
            errors++;
            $display("FAIL clash_one_cycle: got %b expected 0", wr_clash);
        end
    endtask

    task automatic test_zero_reg();
        drive_idle();
        wr_en    = 2'b11;
        wr_data0 = 32'hFFFF_FFFF;
        wr_data1 = 32'hFFFF_FFFF;
        rd_addr  = {5'd0, 5'd0};
        #1;
        checks++;
        if (rd_data !== {NUM_RD*XLEN{1'b0}}) begin
            errors++;
            $display("FAIL zero_same_cycle: got %h expected 0", rd_data);
        end
        step();
        drive_idle();
        #1;
        checks++;
        if (rd_data[31:0] !== 32'd0) begin
            errors++;
            $display("FAIL zero_read: got %h expected 0", rd_data[31:0]);
        end
        checks++;
        if (wr_clash !== 1'b0) begin
            errors++;
            $display("FAIL zero_no_clash: got %b expected 0", wr_clash);
        end
        step();
    endtask

    task automatic test_random();
        logic [AW-1:0]   a0, a1;
        logic [XLEN-1:0] e0, e1;
        for (int c = 0; c < 400; c++) begin
            a0 = AW'($urandom_range(0, 7));
            a1 = AW'($urandom_range(0, NUM_REGS-1));
            rd_addr  = {a1, a0};
            wr_en    = 2'($urandom_range(0, 3));
            wr_addr0 = AW'($urandom_range(0, 7));
            wr_addr1 = AW'($urandom_range(0, 7));
            wr_data0 = $urandom;
            wr_data1 = $urandom;
            #1;
            e0 = exp_rd(a0);
            e1 = exp_rd(a1);
            checks++;
            if (rd_data[31:0] !== e0) begin
                errors++;
                $display("FAIL rand_rd0 cycle %0d addr %0d: got %h expected %h", c, a0, rd_data[31:0], e0);
            end
            checks++;
            if (rd_data[63:32] !== e1) begin
                errors++;
                $display("FAIL rand_rd1 cycle %0d addr %0d: got %h expected %h", c, a1, rd_data[63:32], e1);
            end
            checks++;
            if (wr_clash !== clash_m) begin
                errors++;
                $display("FAIL rand_clash cycle %0d: got %b expected %b", c, wr_clash, clash_m);
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        drive_idle();
        wr_en    = 2'b01;
        wr_addr0 = 5'd9;
        wr_data0 = 32'h0000_CAFE;
        step();
        drive_idle();
        rd_addr = {5'd0, 5'd9};
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h0000_CAFE) begin
            errors++;
            $display("FAIL cafe_written: got %h expected 0000cafe", rd_data[31:0]);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        // part-way through INIT, pulse reset again: the walk must restart from zero
        for (int c = 0; c < 15; c++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int c = 0; c < NUM_REGS + 2; c++) begin
            #1;
            checks++;
            if (ready !== ready_m) begin
                errors++;
                $display("FAIL reinit_ready cycle %0d: got %b expected %b", c, ready, ready_m);
            end
            step();
        end
        #1;
        checks++;
        if (rd_data[31:0] !== 32'd9) begin
            errors++;
            $display("FAIL reinit_value_9: got %h expected 00000009", rd_data[31:0]);
        end
    endtask

    initial begin
        reset   = 1'b1;
        rd_addr = {NUM_RD*AW{1'b0}};
        drive_idle();
        @(negedge clock);
        test_reset();
        test_write_read();
        test_clash();
        test_zero_reg();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
